// File: rtl/hockey_input_sched.sv
// Input front-end for the hockey core: synchronises and debounces both buttons, captures
// one pending command per player, offers them one at a time over valid/ready, paces the puck.
module hockey_input_sched #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int STEP_DIV     = 50,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_a_raw,
    input  logic       btn_b_raw,
    input  logic [1:0] dir_a,
    input  logic [1:0] dir_b,
    input  logic [2:0] y_a,
    input  logic [2:0] y_b,
    input  logic [1:0] turn,
    input  logic       step_en,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic       cmd_player,
    output logic [1:0] cmd_dir,
    output logic [2:0] cmd_y,
    output logic       step_tick,
    output logic       rej_a,
    output logic       rej_b
);

    typedef enum logic {IDLE, OFFER} state_t;

    // Index 0 is player A, index 1 is player B throughout.
    logic [1:0]       btn_raw, sync1, sync2, warm;
    logic [1:0]       db_level, armed, flip, press;
    logic [CNT_W-1:0] db_cnt [2];
    logic [1:0]       dir_in [2];
    logic [2:0]       y_in   [2];

    logic [1:0]       pending, offering, accept_p, flush, press_rej, store, elig;
    logic [1:0]       pend_dir [2];
    logic [2:0]       pend_y   [2];
    logic             accept, sel, rr_ptr, rr_d;

    state_t           state_q, state_d;
    logic             valid_d, player_d;
    logic [1:0]       dir_d;
    logic [2:0]       y_d;
    logic [CNT_W-1:0] step_cnt;

    assign btn_raw   = {btn_b_raw, btn_a_raw};
    assign dir_in[0] = dir_a;
    assign dir_in[1] = dir_b;
    assign y_in[0]   = y_a;
    assign y_in[1]   = y_b;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            warm  <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            warm  <= {warm[0], 1'b1};
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            flip[p] = (sync2[p] != db_level[p]) && (db_cnt[p] == CNT_W'(DEBOUNCE_CYC - 1));
        end
    end

    // A press only counts once the button has been seen released after reset.
    assign press = flip & ~db_level & armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_level <= '0;
            armed    <= '0;
            for (int p = 0; p < 2; p++) db_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                armed[p] <= armed[p] | (warm[1] & ~sync2[p] & ~db_level[p]);
                if (sync2[p] == db_level[p]) begin
                    db_cnt[p] <= '0;
                end else if (flip[p]) begin
                    db_level[p] <= ~db_level[p];
                    db_cnt[p]   <= '0;
                end else begin
                    db_cnt[p] <= db_cnt[p] + CNT_W'(1);
                end
            end
        end
    end

    assign accept    = cmd_valid & cmd_ready;
    assign offering  = {cmd_valid & cmd_player, cmd_valid & ~cmd_player};
    assign accept_p  = offering & {2{cmd_ready}};
    // An offered command is never flushed; only idle pendings lose their turn.
    assign flush     = pending & ~turn & ~offering;
    assign press_rej = press & (~turn | (pending & ~accept_p));
    assign store     = press & ~press_rej;

    // NOTE: the payload registers are reset too, so nothing undefined can reach cmd_dir/cmd_y.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            rej_a   <= 1'b0;
            rej_b   <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                pend_dir[p] <= '0;
                pend_y[p]   <= '0;
            end
        end else begin
            rej_a <= press_rej[0] | flush[0];
            rej_b <= press_rej[1] | flush[1];
            for (int p = 0; p < 2; p++) begin
                if (store[p]) begin
                    pending[p]  <= 1'b1;
                    pend_dir[p] <= dir_in[p];
                    pend_y[p]   <= y_in[p];
                end else if (accept_p[p] | flush[p]) begin
                    pending[p] <= 1'b0;
                end
            end
        end
    end

    assign elig = pending & turn;
    assign sel  = (&elig) ? rr_ptr : elig[1];

    always_comb begin
        state_d  = state_q;
        valid_d  = cmd_valid;
        player_d = cmd_player;
        dir_d    = cmd_dir;
        y_d      = cmd_y;
        rr_d     = rr_ptr;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d  = OFFER;
                    valid_d  = 1'b1;
                    player_d = sel;
                    dir_d    = pend_dir[sel];
                    y_d      = pend_y[sel];
                end
            end
            OFFER: begin
                if (cmd_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    rr_d    = ~cmd_player;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cmd_valid  <= 1'b0;
            cmd_player <= 1'b0;
            cmd_dir    <= '0;
            cmd_y      <= '0;
            rr_ptr     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_valid  <= valid_d;
            cmd_player <= player_d;
            cmd_dir    <= dir_d;
            cmd_y      <= y_d;
            rr_ptr     <= rr_d;
        end
    end

    // A hit restarts the puck period so the first step after it is a full STEP_DIV away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_cnt <= '0;
        end else if (!step_en || accept) begin
            step_cnt <= '0;
        end else if (step_cnt == CNT_W'(STEP_DIV - 1)) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + CNT_W'(1);
        end
    end

    assign step_tick = step_en & (step_cnt == CNT_W'(STEP_DIV - 1));

endmodule
